// File: rtl/day01_pkg.sv
// Shared constants and types for the day-01 ASCII command parser.
// Holds the byte values the parser recognises and its state encoding.
package day01_pkg;

    localparam int STEPS_W_DEFAULT = 32;

    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_NL = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    typedef enum logic [1:0] {
        IDLE,
        DIGITS,
        EMIT,
        SKIP
    } state_e;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/day01_digit_acc.sv
// Decimal accumulator step: sum = acc*10 + digit, with a flag when the
// result no longer fits in STEPS_W bits.
module day01_digit_acc #(
    parameter int STEPS_W = 32
) (
    input  logic [STEPS_W-1:0] acc,
    input  logic [3:0]         digit,
    output logic [STEPS_W-1:0] sum,
    output logic               overflow
);

    // Four extra bits are enough: 10*(2^W-1)+9 < 16*2^W.
    logic [STEPS_W+3:0] wide;

    always_comb begin
        wide     = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                 + {{STEPS_W{1'b0}}, digit};
        sum      = wide[STEPS_W-1:0];
        overflow = |wide[STEPS_W+3:STEPS_W];
    end

endmodule

// File: rtl/day01_cmd_parser.sv
// Streaming ASCII front end: turns "L68\n"-style lines into {dir, steps}
// commands on a valid/ready interface, dropping malformed lines.
module day01_cmd_parser
    import day01_pkg::*;
#(
    parameter int STEPS_W = STEPS_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               valid,
    output logic               dir,
    output logic [STEPS_W-1:0] steps,
    input  logic               ready,
    output logic [31:0]        cmd_count,
    output logic               err,
    output logic               done
);

    state_e             state_q, state_d;
    logic [STEPS_W-1:0] acc_q, acc_d;
    logic               dir_q, dir_d;
    logic               have_digit_q, have_digit_d;
    logic [31:0]        cmd_count_q, cmd_count_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               last_q, last_d;

    logic [STEPS_W-1:0] acc_sum;
    logic               acc_ovf;
    logic               byte_xfer;
    logic               cmd_xfer;

    day01_digit_acc #(
        .STEPS_W(STEPS_W)
    ) u_digit_acc (
        .acc     (acc_q),
        .digit   (in_data[3:0]),
        .sum     (acc_sum),
        .overflow(acc_ovf)
    );

    assign in_ready  = (state_q != EMIT) && !last_q;
    assign valid     = (state_q == EMIT);
    assign dir       = dir_q;
    assign steps     = acc_q;
    assign cmd_count = cmd_count_q;
    assign err       = err_q;
    assign done      = done_q;
    assign byte_xfer = in_valid && in_ready;
    assign cmd_xfer  = valid && ready;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        dir_d        = dir_q;
        have_digit_d = have_digit_q;
        cmd_count_d  = cmd_count_q;
        err_d        = err_q;
        done_d       = done_q;
        last_d       = last_q;

        if (byte_xfer) begin
            case (state_q)
                IDLE: begin
                    if (in_data == CH_L || in_data == CH_R) begin
                        dir_d        = (in_data == CH_R);
                        acc_d        = '0;
                        have_digit_d = 1'b0;
                        state_d      = DIGITS;
                    end else if (in_data != CH_NL && in_data != CH_CR) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
                DIGITS: begin
                    if (is_digit(in_data)) begin
                        if (acc_ovf) begin
                            err_d   = 1'b1;
                            state_d = SKIP;
                        end else begin
                            acc_d        = acc_sum;
                            have_digit_d = 1'b1;
                        end
                    end else if (in_data == CH_NL) begin
                        if (have_digit_q) begin
                            state_d = EMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (in_data != CH_CR) begin
                        err_d   = 1'b1;
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (in_data == CH_NL) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase

            // The final byte closes the line whether or not it was a newline.
            if (in_last) begin
                last_d = 1'b1;
                if (state_d == EMIT || (state_d == DIGITS && have_digit_d)) begin
                    state_d = EMIT;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        if (cmd_xfer) begin
            state_d     = IDLE;
            cmd_count_d = cmd_count_q + 32'd1;
            if (last_q) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            dir_q        <= 1'b0;
            have_digit_q <= 1'b0;
            cmd_count_q  <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            dir_q        <= dir_d;
            have_digit_q <= have_digit_d;
            cmd_count_q  <= cmd_count_d;
            err_q        <= err_d;
            done_q       <= done_d;
            last_q       <= last_d;
        end
    end

endmodule

// File: tb/tb_day01_cmd_parser.sv
// Self-checking bench for day01_cmd_parser: directed cases plus random
// byte streams compared against a line-level reference model.
module tb_day01_cmd_parser;
    import day01_pkg::*;

    localparam int W     = 32;
    localparam int LIMIT = 4000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         valid;
    logic         dir;
    logic [W-1:0] steps;
    logic         ready;
    logic [31:0]  cmd_count;
    logic         err;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned stim[$];
    logic [W:0]   exp_cmd[$];
    bit           exp_err;

    day01_cmd_parser #(.STEPS_W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .valid    (valid),
        .dir      (dir),
        .steps    (steps),
        .ready    (ready),
        .cmd_count(cmd_count),
        .err      (err),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: one line at a time, carriage returns carry no meaning.
    function automatic void model_line(input byte unsigned l[$], input bit term);
        longint unsigned v   = 0;
        bit              bad = 0;
        if (l.size() == 0) return;
        if (l[0] != CH_L && l[0] != CH_R) begin
            exp_err = 1;
            return;
        end
        if (l.size() == 1) begin
            if (term) exp_err = 1;
            return;
        end
        for (int j = 1; j < l.size(); j++) begin
            if (l[j] < CH_0 || l[j] > CH_9) begin
                bad = 1;
                break;
            end
            v = v * 10 + 64'(l[j] - CH_0);
            if (v > 64'hFFFF_FFFF) begin
                bad = 1;
                break;
            end
        end
        if (bad) begin
            exp_err = 1;
            return;
        end
        exp_cmd.push_back({l[0] == CH_R, v[31:0]});
    endfunction

    function automatic void model();
        byte unsigned line[$];
        exp_cmd.delete();
        exp_err = 0;
        for (int i = 0; i < stim.size(); i++) begin
            if (stim[i] == CH_NL) begin
                model_line(line, 1'b1);
                line.delete();
            end else if (stim[i] != CH_CR) begin
                line.push_back(stim[i]);
            end
        end
        model_line(line, 1'b0);
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic load(input string s);
        stim.delete();
        push_str(s);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        ready    = 1'b0;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_dir", 64'(dir), 64'd0);
        check("rst_steps", 64'(steps), 64'd0);
        check("rst_cmd_count", 64'(cmd_count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offers one byte and returns once it will be taken at the next edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("send_timeout", 64'(waited < 100), 64'd1);
    endtask

    // Plays stim (last byte flagged in_last) and checks every cycle against the model.
    task automatic run_stream(input int vpct, input int rpct, output int got);
        int         n        = stim.size();
        int         idx      = 0;
        bit         hold     = 0;
        bit         finished = 0;
        logic [W:0] hold_cmd = '0;
        logic [W:0] e;
        got = 0;
        model();
        for (int cyc = 0; cyc < LIMIT; cyc++) begin
            @(negedge clk);
            in_valid = (idx < n) && ($urandom_range(99) < vpct);
            in_data  = (idx < n) ? stim[idx] : 8'h00;
            in_last  = (idx == n - 1);
            ready    = ($urandom_range(99) < rpct);
            #1;
            check("done", 64'(done), 64'(idx == n && exp_cmd.size() == 0));
            if (done && idx == n && exp_cmd.size() == 0) begin
                finished = 1;
                check("in_ready_locked", 64'(in_ready), 64'd0);
                break;
            end
            if (idx == n) check("in_ready_locked", 64'(in_ready), 64'd0);
            else          check("in_ready", 64'(in_ready), 64'(!valid));
            if (hold) check("valid_hold", 64'({valid, dir, steps}), 64'({1'b1, hold_cmd}));
            if (valid && ready) begin
                check("cmd_avail", 64'(exp_cmd.size() > 0), 64'd1);
                if (exp_cmd.size() > 0) begin
                    e = exp_cmd.pop_front();
                    check("cmd", 64'({dir, steps}), 64'(e));
                end
                $display("cmd %0d: dir=%0d steps=%0d", got, dir, steps);
                got++;
            end
            hold     = valid && !ready;
            hold_cmd = {dir, steps};
            if (in_valid && in_ready) idx++;
        end
        check("stream_timeout", 64'(finished), 64'd1);
        check("cmds_left", 64'(exp_cmd.size()), 64'd0);
        check("cmd_count", 64'(cmd_count), 64'(got));
        check("err", 64'(err), 64'(exp_err));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic gen_random();
        int nl = $urandom_range(1, 8);
        stim.delete();
        for (int i = 0; i < nl; i++) begin
            int          kind = $urandom_range(0, 9);
            logic [31:0] val;
            case ($urandom_range(0, 2))
                0:       val = 32'($urandom_range(0, 999));
                1:       val = $urandom;
                default: val = 32'hFFFF_FFFF;
            endcase
            if (kind <= 4) begin
                stim.push_back($urandom_range(1) != 0 ? CH_R : CH_L);
                if ($urandom_range(3) == 0) stim.push_back(CH_CR);
                push_str($sformatf("%0d", val));
                if ($urandom_range(3) == 0) stim.push_back(CH_CR);
                stim.push_back(CH_NL);
            end else if (kind == 5) begin
                if ($urandom_range(1) != 0) stim.push_back(CH_CR);
                stim.push_back(CH_NL);
            end else if (kind == 6) begin
                push_str($sformatf("X%0d\n", val));
            end else if (kind == 7) begin
                push_str("R\n");
            end else if (kind == 8) begin
                push_str($sformatf("L%0d\n", 64'd4294967296 + 64'($urandom_range(0, 1000))));
            end else begin
                push_str("R1a2\n");
            end
        end
        if ($urandom_range(1) != 0 && stim.size() > 1 && stim[stim.size() - 1] == CH_NL)
            void'(stim.pop_back());
    endtask

    initial begin
        int got;

        // Two plain commands, ready always high.
        do_reset();
        load("R14\nL68\n");
        run_stream(100, 100, got);
        check("basic_ncmd", 64'(got), 64'd2);
        check("basic_err", 64'(err), 64'd0);

        // Back-pressure: command held stable, next byte stalled.
        do_reset();
        send_byte(CH_L, 1'b0);
        send_byte(8'h35, 1'b0);
        send_byte(CH_NL, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = CH_R;
            in_last  = 1'b0;
            ready    = 1'b0;
            #1;
            check("stall_valid", 64'(valid), 64'd1);
            check("stall_steps", 64'(steps), 64'd5);
            check("stall_dir", 64'(dir), 64'd0);
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        ready = 1'b1;
        #1;
        check("stall_cnt_before", 64'(cmd_count), 64'd0);
        @(negedge clk);
        ready    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("stall_cnt_after", 64'(cmd_count), 64'd1);
        check("stall_valid_after", 64'(valid), 64'd0);
        check("stall_in_ready_after", 64'(in_ready), 64'd1);

        // Malformed first line dropped.
        do_reset();
        load("X9\nR3\n");
        run_stream(100, 100, got);
        check("bad_ncmd", 64'(got), 64'd1);
        check("bad_err", 64'(err), 64'd1);

        // Overflow by one, then the maximum value.
        do_reset();
        load("R4294967296\nL1\n");
        run_stream(100, 100, got);
        check("ovf_ncmd", 64'(got), 64'd1);
        check("ovf_err", 64'(err), 64'd1);
        do_reset();
        load("R4294967295\n");
        run_stream(100, 100, got);
        check("max_ncmd", 64'(got), 64'd1);
        check("max_steps", 64'(steps), 64'hFFFF_FFFF);

        // Blank lines and an unterminated final line.
        do_reset();
        load("\r\n\nR7");
        run_stream(100, 100, got);
        check("noterm_ncmd", 64'(got), 64'd1);

        // Asynchronous reset while a command is waiting.
        do_reset();
        ready = 1'b1;
        send_byte(CH_R, 1'b0);
        send_byte(8'h31, 1'b0);
        send_byte(CH_NL, 1'b0);
        send_byte(CH_L, 1'b0);
        ready = 1'b0;
        send_byte(8'h39, 1'b0);
        send_byte(CH_NL, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 64'(valid), 64'd1);
        check("pre_rst_cnt", 64'(cmd_count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(valid), 64'd0);
        check("mid_rst_cnt", 64'(cmd_count), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_steps", 64'(steps), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load("L2\n");
        run_stream(100, 100, got);
        check("post_rst_ncmd", 64'(got), 64'd1);

        // Random streams with random stalls on both sides.
        for (int t = 0; t < 40; t++) begin
            do_reset();
            gen_random();
            run_stream($urandom_range(50, 100), $urandom_range(30, 100), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/day01_cmd_parser.md
# day01_cmd_parser

Streaming ASCII front end for the day-01 dial solver. Consumes the puzzle input one byte per transfer (lines such as `L68` / `R14`, newline-terminated) and emits one `{dir, steps}` command per line on the valid/ready interface that `day01_part1` accepts. It moves file parsing into hardware, so a bench or UART bridge only needs to push raw bytes.

## Interface
- `STEPS_W`, default 32: width of the `steps` output and the internal accumulator.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  byte on `in_data` is offered.
- `in_data`  input  8  ASCII byte.
- `in_last`  input  1  qualifies the current byte as the final byte of the input.
- `in_ready`  output  1  parser can accept a byte this cycle.
- `valid`  output  1  command on `dir`/`steps` is offered to the solver.
- `dir`  output  1  1 = `R`, 0 = `L`.
- `steps`  output  STEPS_W  decimal value parsed from the line.
- `ready`  input  1  solver can accept a command.
- `cmd_count`  output  32  number of commands transferred (`valid && ready`).
- `err`  output  1  sticky; at least one malformed line was dropped.
- `done`  output  1  sticky; `in_last` byte consumed and no command pending.

## Operation
- A byte transfers when `in_valid && in_ready` at a rising edge. A command transfers when `valid && ready` at a rising edge.
- States:
  - **IDLE**: expects a direction. `L`/`R` latches `dir`, clears the accumulator, and goes to DIGITS. `\n` and `\r` are ignored (blank line). Any other byte sets `err` and goes to SKIP.
  - **DIGITS**: for `0`–`9`, `acc <= acc*10 + digit`, computed at STEPS_W+4 bits. A result above 2^STEPS_W−1 sets `err` and goes to SKIP. `\r` is ignored. `\n` with at least one digit goes to EMIT. `\n` with zero digits sets `err` and goes to IDLE. Any other byte sets `err` and goes to SKIP.
  - **EMIT**: `valid=1`, `steps=acc`. Stays until a command transfer, then returns to IDLE.
  - **SKIP**: discards bytes up to and including `\n`, then returns to IDLE.
- `in_ready = (state != EMIT)`. `dir` and `steps` are stable while `valid` is high.
- `in_last` on a consumed byte ends the current line. A final line with no trailing `\n`:
  - If at least one digit has been parsed (including the digit in this last byte), go to EMIT.
  - Otherwise, drop the line silently.
- After the `in_last` byte is consumed, `in_ready` stays 0 until reset.
- `done` rises in the cycle after the last command transfer. If there is nothing left to emit, it rises in the cycle after the `in_last` byte is consumed.
- `cmd_count` increments once per command transfer and wraps modulo 2^32.

## Timing
- Reset values: `in_ready=1`, `valid=0`, `dir=0`, `steps=0`, `cmd_count=0`, `err=0`, `done=0`, state IDLE, accumulator 0.
- Latency: terminating `\n` accepted at edge N → `valid=1` after edge N; earliest command transfer at edge N+1.
- Back-to-back throughput: one line of k bytes takes k cycles plus at least 1 cycle in EMIT. Bytes are stalled (`in_ready=0`) while EMIT waits on `ready`.
- `ready` may be high before `valid` rises. A transfer requires both signals high at the same edge. `valid` must not drop without a transfer.
- Reset assertion mid-line or mid-EMIT returns all state to the reset values immediately, without waiting for a clock edge. A partially parsed line is lost.
- `in_valid` with `in_ready=0`: the byte is not consumed, and no state changes.

## Structure
- Package `day01_pkg`:
  - ASCII constants `CH_L`, `CH_R`, `CH_NL`, `CH_CR`, `CH_0`, `CH_9`.
  - Parser state enum `{IDLE, DIGITS, EMIT, SKIP}`.
  - Default `STEPS_W`.
- One sub-module, `day01_digit_acc`: combinational `acc*10+digit` with overflow flag, parameterised by STEPS_W.
- FSM, handshake, and counters live in the top.

## Test plan
- Bytes `R14\nL68\n`, `ready` tied 1 → commands {1,14} then {0,68}; `cmd_count=2`; `err=0`; `done=0` until `in_last`.
- `L5\n` with `ready` held 0 for 4 cycles → `valid` high and `steps=5` stable all 4 cycles. `in_ready=0` throughout; the next byte `R` stalls. Transfer occurs on the first edge with `ready=1`.
- `X9\nR3\n` → `err=1` and the first line is dropped; a single command {1,3} is emitted.
- `R4294967296\nL1\n` (STEPS_W=32) → overflow sets `err`; only {0,1} is emitted. `R4294967295\n` → `steps=32'hFFFFFFFF`.
- `\r\n\nR7` with `in_last` on `7`, no trailing `\n` → a single command {1,7}. `done=1` in the cycle after its transfer; `in_ready` stays 0 afterwards.
- `rst_n` pulled low while in EMIT with `ready=0` → `valid=0`, `cmd_count=0`, state IDLE. After release, `L2\n` yields {0,2}.
